// File: rtl/ix_muldiv_unit_if.sv
// IX-stage multiply/divide unit bus: ID/IX operands in, HI/LO and stall out.
// master = pipeline side, slave = ix_muldiv_unit.
interface ix_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic [5:0]      alu_op_in;
    logic [XLEN-1:0] A_in;
    logic [XLEN-1:0] B_in;
    logic            flush;
    logic            stall_out;
    logic [XLEN-1:0] result_out;
    logic            result_valid;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    logic            busy;
    logic            div_by_zero;

    modport master (
        output valid_in, alu_op_in, A_in, B_in, flush,
        input  stall_out, result_out, result_valid,
        input  hi_out, lo_out, busy, div_by_zero
    );

    modport slave (
        input  valid_in, alu_op_in, A_in, B_in, flush,
        output stall_out, result_out, result_valid,
        output hi_out, lo_out, busy, div_by_zero
    );
endinterface

// File: rtl/ix_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply.
module ix_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic clk,
    input logic rst,
    ix_muldiv_unit_if.slave bus
);
    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              op_div;
    logic              neg_q;
    logic              neg_r;
    logic              dbz;
    logic [XLEN-1:0]   raw_a;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   mq;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;

    logic              is_mul;
    logic              is_div;
    logic              is_sgn;
    logic              start;
    logic              wr_hi;
    logic              wr_lo;
    logic              rd_op;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Decode the ID/IX op and prepare magnitude operands for the accept cycle.
    always_comb begin
        is_mul = (bus.alu_op_in == OP_MULT) | (bus.alu_op_in == OP_MULTU);
        is_div = (bus.alu_op_in == OP_DIV) | (bus.alu_op_in == OP_DIVU);
        is_sgn = (bus.alu_op_in == OP_MULT) | (bus.alu_op_in == OP_DIV);
        start  = (state == IDLE) & bus.valid_in & ~bus.flush & (is_mul | is_div);
        wr_hi  = (state == IDLE) & bus.valid_in & ~bus.flush
               & (bus.alu_op_in == OP_MTHI);
        wr_lo  = (state == IDLE) & bus.valid_in & ~bus.flush
               & (bus.alu_op_in == OP_MTLO);
        rd_op  = (bus.alu_op_in == OP_MFHI) | (bus.alu_op_in == OP_MFLO);
        sign_a = is_sgn & bus.A_in[XLEN-1];
        sign_b = is_sgn & bus.B_in[XLEN-1];
        abs_a  = sign_a ? -bus.A_in : bus.A_in;
        abs_b  = sign_b ? -bus.B_in : bus.B_in;
`ifdef MULDIV_FAST_MUL_EN
        ext_a     = {{XLEN{sign_a}}, bus.A_in};
        ext_b     = {{XLEN{sign_b}}, bus.B_in};
        fast_prod = ext_a * ext_b;
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring compare for divide.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        div_shift = {acc, mq[XLEN-1]};
        div_ok    = div_shift >= {1'b0, opb};
        prod_fix  = neg_q ? -{acc, mq} : {acc, mq};
        quo_fix   = neg_q ? -mq : mq;
        rem_fix   = neg_r ? -acc : acc;
    end

    assign bus.stall_out    = start | ((state == CALC) & ~bus.flush);
    assign bus.busy         = (state != IDLE);
    assign bus.div_by_zero  = (state == FIX) & dbz;
    assign bus.hi_out       = hi;
    assign bus.lo_out       = lo;
    assign bus.result_valid = bus.valid_in & rd_op & (state == IDLE);
    assign bus.result_out   = ~bus.result_valid ? '0
                            : (bus.alu_op_in == OP_MFHI) ? hi : lo;

    // Sequencer, working registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            raw_a  <= '0;
            opb    <= '0;
            acc    <= '0;
            mq     <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_hi) hi <= bus.A_in;
                    if (wr_lo) lo <= bus.A_in;
                    if (start) begin
                        op_div <= is_div;
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        dbz    <= is_div & (bus.B_in == '0);
                        raw_a  <= bus.A_in;
                        opb    <= is_div ? abs_b : abs_a;
                        acc    <= '0;
                        mq     <= is_div ? abs_a : abs_b;
                        count  <= '0;
                        state  <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (is_mul) begin
                            neg_q <= 1'b0;
                            acc   <= fast_prod[2*XLEN-1:XLEN];
                            mq    <= fast_prod[XLEN-1:0];
                            state <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (op_div) begin
                            acc <= div_ok ? XLEN'(div_shift - {1'b0, opb})
                                          : div_shift[XLEN-1:0];
                            mq  <= {mq[XLEN-2:0], div_ok};
                        end else begin
                            acc <= mul_sum[XLEN:1];
                            mq  <= {mul_sum[0], mq[XLEN-1:1]};
                        end
                        if (count == CNT_W'(XLEN - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        if (dbz) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*XLEN-1:XLEN];
                            lo <= prod_fix[XLEN-1:0];
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ix_muldiv_unit.md
Name: ix_muldiv_unit

Overview:
- Iterative multiply/divide unit in the IX stage, fed by the alu_op/A/B outputs of the ID/IX pipeline register.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Raises stall_out while a multi-cycle operation is in flight, so fetch/decode and ID/IX hold their contents.

Parameters:
- XLEN, 32, operand/HI/LO width
- CNT_W, 5, iteration counter width (2^CNT_W == XLEN)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  ID/IX holds a valid instruction for IX
- alu_op_in  in  6  MIPS funct code: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- A_in  in  XLEN  rs value (multiplicand/dividend; MTHI/MTLO source)
- B_in  in  XLEN  rt value (multiplier/divisor)
- flush  in  1  squash the in-flight op (branch/jump redirect)
- stall_out  out  1  freeze upstream stages and ID/IX
- result_out  out  XLEN  MFHI/MFLO read data, else 0
- result_valid  out  1  valid_in & (op==MFHI | op==MFLO) & state==IDLE
- hi_out  out  XLEN  current HI
- lo_out  out  XLEN  current LO
- busy  out  1  state != IDLE
- div_by_zero  out  1  one-cycle pulse during FIX of a DIV/DIVU with B==0

Behaviour:
- Reset (async): state=IDLE, count=0, HI=LO=0, all working registers 0, all outputs 0.
- start = state==IDLE & valid_in & ~flush & op in {MULT, MULTU, DIV, DIVU}.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On start: latch the operation type and signedness.
  - Latch |A| and |B| when signed, raw A and B otherwise.
  - Latch result sign: MULT uses signA^signB; DIV quotient uses signA^signB, remainder uses signA.
  - Set count=0 and go to CALC.
- IDLE, MTHI/MTLO: with valid_in, write A_in into HI/LO at the edge; stay IDLE; no stall.
- CALC:
  - One radix-2 step per cycle; count increments each cycle.
  - At count==XLEN-1, go to FIX.
  - Multiply: shift-add into a 64-bit {acc, multiplier} register.
  - Divide: restoring shift-subtract; the quotient bit is set when the trial remainder is >= 0.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - Write HI (upper product or remainder) and LO (lower product or quotient) at the edge, then go to IDLE.
- stall_out = start | (state==CALC).
  - It is low in FIX, so the pipeline advances and the same instruction is not restarted.
  - Total stall is 33 cycles: the accept cycle plus 32 CALC cycles.
- Latency: HI/LO are updated at the edge leaving FIX, 34 edges after acceptance. An MFHI that immediately follows reads the new value.
- Divide by zero:
  - LO=0xFFFFFFFF and HI=A_in (raw dividend), for both signed and unsigned forms.
  - Signs are not applied; div_by_zero=1 during FIX.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- MFHI/MFLO: result_out is combinational from HI/LO, gated by result_valid.
- flush:
  - In CALC or FIX: return to IDLE at the next edge with HI/LO unchanged; stall_out drops combinationally.
  - In IDLE: suppresses start and MTHI/MTLO writes.
- Reset mid-operation: immediate return to IDLE with HI=LO=0; no partial write.
- valid_in/alu_op changes while busy are ignored, since the operands are latched.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full 64-bit product with a single-cycle array multiply.
  - Accept goes directly to FIX, skipping CALC, so stall_out is high for 1 cycle only.
  - Divides are unchanged.
- Undefined: iterative 32-cycle multiply as specified above.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=7 -> stall_out high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF2; MFHI next returns 0xFFFFFFFF.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=-100, B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- DIV A=5, B=0 -> div_by_zero pulses 1 cycle; LO=0xFFFFFFFF, HI=5. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI A=0x12345678 then MFHI -> result_out=0x12345678, result_valid=1, no stall; MTLO under flush -> LO unchanged.
- MULTU 3*5 with flush asserted at CALC count 10 -> IDLE next edge, stall_out low, HI/LO keep prior values; rst pulse mid-DIVU -> IDLE, HI=LO=0.
- With MULDIV_FAST_MUL_EN: MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall 1 cycle; HI=0xFFFFFFFE, LO=0x00000001.
